text_write_engine: RTL and testbench
====================================

TEXT_WRITE_ENGINE -- requirements
Module: text_write_engine

Interface
REQ-001 The block SHALL have parameter NR_COLS, default 80, characters per line (2..127).
REQ-002 The block SHALL have parameter NR_ROWS, default 60, lines per screen (2..127); NR_COLS*NR_ROWS SHALL be <= 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, character FIFO entries (power of two, >= 2).
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 13, character RAM address width.
REQ-005 The block SHALL have parameter CI_NR, default 8'd0, custom-instruction number served.
REQ-006 The block SHALL have port clock, input, 1, single clock; all state on rising edge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous, active-low.
REQ-008 The block SHALL have ports ciN (input, 8), ciDataA (input, 32), ciDataB (input, 32), ciStart (input, 1) and ciCke (input, 1), the custom-instruction request.
REQ-009 The block SHALL have ports ciDone (output, 1) and ciResult (output, 32), the custom-instruction response.
REQ-010 The block SHALL have ports ramWe (output, 1), ramAddress (output, ADDR_WIDTH) and ramData (output, 8), the character RAM write port.
REQ-011 The block SHALL have ports scrollOffset (output, ADDR_WIDTH), RAM address of screen row 0, and busy (output, 1), high when not IDLE or FIFO non-empty.

Function
REQ-012 A request SHALL be accepted when ciN==CI_NR and ciStart&ciCke; ciDataA[3:0] selects the command.
REQ-013 Cmd 0 (put char) SHALL push ciDataB[7:0] into the FIFO; if not full, ciDone is high the same cycle; if full, ciDone is held low until a slot frees, then the push and ciDone occur together.
REQ-014 Cmd 1 (clear) SHALL flush the FIFO, zero cursor and scrollOffset, and enter CLEAR_SCREEN; ciDone is high the same cycle.
REQ-015 Cmd 2 (set cursor) SHALL load cursorX=ciDataB[6:0] and cursorY=ciDataB[22:16], each clamped to NR_COLS-1 and NR_ROWS-1; it takes effect only once the FIFO is empty and the FSM is in IDLE, with ciDone held low until then.
REQ-016 Read cmds SHALL return with ciDone in the same cycle: 8 -> {9'd0,cursorY,9'd0,cursorX}; 9 -> {busy, 31'd0 ORed with FIFO count in bits[15:0]}; 15 -> {9'd0,NR_ROWS,9'd0,NR_COLS}.
REQ-017 Other commands SHALL give ciDone=1 and no effect; ciResult SHALL be 0 whenever the request is not an accepted read.
REQ-018 FSM states SHALL be CLEAR_SCREEN, IDLE, EXEC and CLEAR_LINE.
REQ-019 CLEAR_SCREEN SHALL write 0x20 to addresses 0..NR_COLS*NR_ROWS-1, one per cycle, then go to IDLE.
REQ-020 IDLE with the FIFO non-empty SHALL pop one char and go to EXEC.
REQ-021 EXEC SHALL last one cycle and return to IDLE, or go to CLEAR_LINE on a scroll.
REQ-022 Char write address SHALL be (scrollOffset + cursorY*NR_COLS + cursorX) mod (NR_COLS*NR_ROWS).
REQ-023 A printable char (0x20..0x7E) SHALL be written with ramWe=1 and cursorX incremented; at X==NR_COLS-1 it wraps to 0 with a line advance.
REQ-024 0x0A SHALL set X=0 and advance the line; 0x0D SHALL set X=0 with no write.
REQ-025 0x08 SHALL, if X>0, decrement X and write 0x20 there; at X=0 it SHALL have no effect.
REQ-026 0x09 SHALL set X to the next multiple of 8, and wrap with a line advance if that is >= NR_COLS.
REQ-027 Other non-printable chars SHALL be dropped.
REQ-028 A line advance SHALL increment Y when Y<NR_ROWS-1; otherwise scrollOffset += NR_COLS (mod NR_COLS*NR_ROWS), Y is unchanged, and the FSM enters CLEAR_LINE.
REQ-029 CLEAR_LINE SHALL write 0x20 across the NR_COLS cells of row Y, then go to IDLE.
REQ-030 The FIFO SHALL accept a push in any state, including CLEAR_*; a simultaneous push and pop keeps the count unchanged, and a push when full and popping succeeds.
REQ-031 Cmd 1 arriving mid-EXEC or mid-CLEAR_LINE SHALL abort it and restart CLEAR_SCREEN at address 0.

Reset
REQ-032 While reset is low, FSM=CLEAR_SCREEN with counter 0, FIFO empty, cursor 0, scrollOffset 0, ciDone=0, ciResult=0, ramWe=0.
REQ-033 After reset releases, a full clear (NR_COLS*NR_ROWS cycles, ramData=0x20) SHALL run before any character is written.
REQ-034 Reset asserted mid-operation SHALL immediately return all state to REQ-032 values, discarding FIFO contents.

Verification
REQ-035 Release reset -> exactly 4800 ramWe pulses at addresses 0..4799 with data 0x20, then busy=0.
REQ-036 Put 'A','B' after clear -> writes 0x41@0, 0x42@1; cmd 8 returns X=2, Y=0.
REQ-037 Cursor at (79,59), put 'Z' -> write @4799; scrollOffset=80; 80 writes of 0x20 @0..79; cursor (0,59).
REQ-038 Push 9 chars during CLEAR_SCREEN (depth 8) -> first 8 ciDone immediate, 9th ciDone delayed until the first pop; all 9 written in order.
REQ-039 Put 0x09 at X=75 -> X=0, Y+1; put 0x08 at X=0 -> no write, cursor unchanged.
REQ-040 Cmd 1 during CLEAR_LINE -> FIFO count 0, restart at address 0, cursor (0,0).

Source files
------------

// File: rtl/text_write_engine.sv
// Text write engine: character-cell writer for a text-mode frame buffer.
// Accepts custom-instruction requests (put char, clear, set cursor, reads),
// buffers characters in a small FIFO and writes them into a character RAM,
// handling cursor movement, control characters and hardware scrolling.
//
// Ports
//   clock, reset        single clock, asynchronous active-low reset
//   ciN/ciDataA/ciDataB custom-instruction request (number, command, operand)
//   ciStart/ciCke       request strobe and clock enable
//   ciDone/ciResult     custom-instruction response
//   ramWe/ramAddress/   character RAM write port
//   ramData
//   scrollOffset        RAM address of screen row 0
//   busy                high when the FSM is not IDLE or the FIFO holds data
//
// state        | meaning
// CLEAR_SCREEN | write 0x20 to every cell, one per cycle
// IDLE         | waiting; pops a character when the FIFO is non-empty
// EXEC         | interpret the popped character (one cycle)
// CLEAR_LINE   | blank the row just scrolled into view
module text_write_engine #(
  parameter int         NR_COLS    = 80,
  parameter int         NR_ROWS    = 60,
  parameter int         FIFO_DEPTH = 8,
  parameter int         ADDR_WIDTH = 13,
  parameter logic [7:0] CI_NR      = 8'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            ciN,
  input  logic [31:0]           ciDataA,
  input  logic [31:0]           ciDataB,
  input  logic                  ciStart,
  input  logic                  ciCke,
  output logic                  ciDone,
  output logic [31:0]           ciResult,
  output logic                  ramWe,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [7:0]            ramData,
  output logic [ADDR_WIDTH-1:0] scrollOffset,
  output logic                  busy
);

  localparam int         TOTAL    = NR_COLS * NR_ROWS;
  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam int         LW       = ADDR_WIDTH + 8;
  localparam logic [6:0] COL_LAST = 7'(NR_COLS - 1);
  localparam logic [6:0] ROW_LAST = 7'(NR_ROWS - 1);

  typedef enum logic [1:0] {CLEAR_SCREEN, IDLE, EXEC, CLEAR_LINE} state_t;

  state_t                state, state_nxt;
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [6:0]            cur_x, cur_y, x_nxt, y_nxt;
  logic [ADDR_WIDTH-1:0] scroll_nxt, cnt, cnt_nxt, addr_nxt;
  logic [7:0]            chr, chr_nxt, data_nxt, tab_x;
  logic                  we_nxt, adv;
  logic                  req, full, empty, push, pop, flush, set_cur;
  logic                  done_c;
  logic [31:0]           result_c;
  logic [3:0]            cmd;
  logic                  unused_bits;

  assign unused_bits = ^{ciDataA[31:4], ciDataB[31:23], ciDataB[15:7]};

  // Cell address (base + row*NR_COLS + col) folded into the RAM range.
  // Both terms are below TOTAL, so a single conditional subtract suffices.
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [6:0] row,
                                                     input logic [6:0] col);
    logic [LW-1:0] s;
    s = LW'(base) + LW'(row) * LW'(NR_COLS) + LW'(col);
    if (s >= LW'(TOTAL)) s = s - LW'(TOTAL);
    return s[ADDR_WIDTH-1:0];
  endfunction

  assign cmd     = ciDataA[3:0];
  assign req     = ciStart && ciCke && (ciN == CI_NR);
  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign flush   = req && (cmd == 4'd1);
  assign pop     = (state == IDLE) && !empty && !flush;
  // A push into a full FIFO succeeds when a pop frees the slot this cycle.
  assign push    = req && (cmd == 4'd0) && (!full || pop);
  assign set_cur = req && (cmd == 4'd2) && (state == IDLE) && empty;
  assign busy    = (state != IDLE) || !empty;
  assign tab_x   = {1'b0, cur_x[6:3], 3'b000} + 8'd8;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= ciDataB[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= CLEAR_SCREEN;
      cnt          <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      scrollOffset <= '0;
      chr          <= '0;
      ramWe        <= 1'b0;
      ramAddress   <= '0;
      ramData      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cur_x        <= x_nxt;
      cur_y        <= y_nxt;
      scrollOffset <= scroll_nxt;
      chr          <= chr_nxt;
      ramWe        <= we_nxt;
      ramAddress   <= addr_nxt;
      ramData      <= data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    x_nxt      = cur_x;
    y_nxt      = cur_y;
    scroll_nxt = scrollOffset;
    chr_nxt    = chr;
    we_nxt     = 1'b0;
    addr_nxt   = '0;
    data_nxt   = 8'h20;
    adv        = 1'b0;
    if (flush) begin
      state_nxt  = CLEAR_SCREEN;
      cnt_nxt    = '0;
      x_nxt      = '0;
      y_nxt      = '0;
      scroll_nxt = '0;
    end else begin
      case (state)
        CLEAR_SCREEN: begin
          we_nxt   = 1'b1;
          addr_nxt = cnt;
          if (cnt == ADDR_WIDTH'(TOTAL - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        IDLE: begin
          if (set_cur) begin
            x_nxt = (ciDataB[6:0]   > COL_LAST) ? COL_LAST : ciDataB[6:0];
            y_nxt = (ciDataB[22:16] > ROW_LAST) ? ROW_LAST : ciDataB[22:16];
          end else if (pop) begin
            chr_nxt   = fifo_mem[rd_ptr];
            state_nxt = EXEC;
          end
        end
        EXEC: begin
          state_nxt = IDLE;
          if (chr >= 8'h20 && chr <= 8'h7E) begin
            we_nxt   = 1'b1;
            addr_nxt = wrap_add(scrollOffset, cur_y, cur_x);
            data_nxt = chr;
            if (cur_x == COL_LAST) begin
              x_nxt = '0;
              adv   = 1'b1;
            end else begin
              x_nxt = cur_x + 7'd1;
            end
          end else begin
            case (chr)
              8'h0A: begin
                x_nxt = '0;
                adv   = 1'b1;
              end
              8'h0D: x_nxt = '0;
              8'h08: begin
                if (cur_x != '0) begin
                  x_nxt    = cur_x - 7'd1;
                  we_nxt   = 1'b1;
                  addr_nxt = wrap_add(scrollOffset, cur_y, cur_x - 7'd1);
                end
              end
              8'h09: begin
                if (tab_x >= 8'(NR_COLS)) begin
                  x_nxt = '0;
                  adv   = 1'b1;
                end else begin
                  x_nxt = tab_x[6:0];
                end
              end
              default: ;
            endcase
          end
          if (adv) begin
            if (cur_y != ROW_LAST) begin
              y_nxt = cur_y + 7'd1;
            end else begin
              // Bottom row: scroll by one line and blank the row that wrapped around.
              scroll_nxt = wrap_add(scrollOffset, 7'd1, 7'd0);
              state_nxt  = CLEAR_LINE;
              cnt_nxt    = '0;
            end
          end
        end
        CLEAR_LINE: begin
          we_nxt   = 1'b1;
          addr_nxt = wrap_add(scrollOffset, cur_y, cnt[6:0]);
          if (cnt == ADDR_WIDTH'(NR_COLS - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = CLEAR_SCREEN;
      endcase
    end
  end

  always_comb begin
    done_c   = 1'b0;
    result_c = '0;
    if (req) begin
      case (cmd)
        4'd0:  done_c = push;
        4'd2:  done_c = set_cur;
        4'd8: begin
          done_c   = 1'b1;
          result_c = {9'd0, cur_y, 9'd0, cur_x};
        end
        4'd9: begin
          done_c   = 1'b1;
          result_c = {busy, 15'd0, 16'(count)};
        end
        4'd15: begin
          done_c   = 1'b1;
          result_c = {9'd0, 7'(NR_ROWS), 9'd0, 7'(NR_COLS)};
        end
        default: done_c = 1'b1;
      endcase
    end
  end

  // The response is combinational, so hold it quiet while reset is asserted.
  assign ciDone   = done_c & reset;
  assign ciResult = reset ? result_c : 32'd0;

endmodule

// File: tb/tb_text_write_engine.sv
module tb_text_write_engine;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciDataA = 32'd0;
  logic [31:0] ciDataB = 32'd0;
  logic        ciStart = 1'b0;
  logic        ciCke = 1'b0;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        ramWe;
  logic [12:0] ramAddress;
  logic [7:0]  ramData;
  logic [12:0] scrollOffset;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  logic [12:0] log_a[$];
  logic [7:0]  log_d[$];

  always #5 clock = ~clock;

  text_write_engine dut (
    .clock(clock), .reset(reset),
    .ciN(ciN), .ciDataA(ciDataA), .ciDataB(ciDataB), .ciStart(ciStart), .ciCke(ciCke),
    .ciDone(ciDone), .ciResult(ciResult),
    .ramWe(ramWe), .ramAddress(ramAddress), .ramData(ramData),
    .scrollOffset(scrollOffset), .busy(busy)
  );

  always @(negedge clock) begin
    if (reset && ramWe) begin
      log_a.push_back(ramAddress);
      log_d.push_back(ramData);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic ci_req(input string tag, input logic [3:0] cmd, input logic [31:0] b,
                        output int waited, output logic [31:0] res);
    @(negedge clock);
    ciN = 8'd0; ciDataA = {28'd0, cmd}; ciDataB = b; ciStart = 1'b1; ciCke = 1'b1;
    waited = 0;
    #1;
    while (ciDone !== 1'b1 && waited < 20000) begin
      @(negedge clock); #1;
      waited++;
    end
    res = ciResult;
    chk({tag, "_done"}, {31'd0, ciDone}, 32'd1);
    @(posedge clock); #1;
    ciStart = 1'b0; ciCke = 1'b0; ciDataA = 32'd0; ciDataB = 32'd0;
  endtask

  task automatic put(input logic [7:0] c);
    int w;
    logic [31:0] r;
    ci_req("put", 4'd0, {24'd0, c}, w, r);
  endtask

  task automatic rd(input string tag, input logic [3:0] cmd, input logic [31:0] exp);
    int w;
    logic [31:0] r;
    ci_req(tag, cmd, 32'd0, w, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
  endtask

  function automatic int clear_bad(input int start);
    int bad = 0;
    for (int i = 0; i < 4800; i++)
      if (log_a[start+i] !== 13'(i) || log_d[start+i] !== 8'h20) bad++;
    return bad;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          bad;
    int          sz;
    logic [31:0] r;

    // Reset: response and RAM port quiet even with a request present.
    ciStart = 1'b1; ciCke = 1'b1; ciDataA = 32'd15;
    repeat (3) @(negedge clock);
    chk("rst_done", {31'd0, ciDone}, 32'd0);
    chk("rst_result", ciResult, 32'd0);
    chk("rst_we", {31'd0, ramWe}, 32'd0);
    chk("rst_scroll", {19'd0, scrollOffset}, 32'd0);
    ciStart = 1'b0; ciCke = 1'b0; ciDataA = 32'd0;

    // Power-up clear.
    reset = 1'b1;
    wait_idle("clr0");
    chk("clr0_count", log_a.size(), 32'd4800);
    if (log_a.size() == 4800) chk("clr0_bad", clear_bad(0), 32'd0);

    // Two characters, then reads.
    log_a.delete(); log_d.delete();
    put(8'h41); put(8'h42);
    wait_idle("ab");
    chk("ab_count", log_a.size(), 32'd2);
    if (log_a.size() == 2) begin
      chk("ab_w0", {11'd0, log_a[0], log_d[0]}, {11'd0, 13'd0, 8'h41});
      chk("ab_w1", {11'd0, log_a[1], log_d[1]}, {11'd0, 13'd1, 8'h42});
    end
    rd("ab_cursor", 4'd8, 32'h0000_0002);
    rd("geom", 4'd15, 32'h003C_0050);
    rd("status_idle", 4'd9, 32'h0000_0000);

    // Requests that must not be accepted.
    @(negedge clock);
    ciN = 8'd3; ciDataA = 32'd15; ciStart = 1'b1; ciCke = 1'b1;
    #1;
    chk("wrong_n_done", {31'd0, ciDone}, 32'd0);
    chk("wrong_n_result", ciResult, 32'd0);
    ciN = 8'd0; ciCke = 1'b0;
    #1;
    chk("no_cke_done", {31'd0, ciDone}, 32'd0);
    ciStart = 1'b0; ciDataA = 32'd0;

    // Clamped cursor at bottom-right, then a scroll.
    log_a.delete(); log_d.delete();
    ci_req("setc_clamp", 4'd2, 32'h007F_007F, w, r);
    rd("clamp_cursor", 4'd8, 32'h003B_004F);
    put(8'h5A);
    wait_idle("scroll");
    chk("scroll_count", log_a.size(), 32'd81);
    if (log_a.size() == 81) begin
      chk("scroll_z", {11'd0, log_a[0], log_d[0]}, {11'd0, 13'd4799, 8'h5A});
      bad = 0;
      for (int i = 0; i < 80; i++)
        if (log_a[1+i] !== 13'(i) || log_d[1+i] !== 8'h20) bad++;
      chk("scroll_line_bad", bad, 32'd0);
    end
    chk("scroll_offset", {19'd0, scrollOffset}, 32'd80);
    rd("scroll_cursor", 4'd8, 32'h003B_0000);

    // Tab wrap, backspace at X=0, then a mixed control sequence.
    log_a.delete(); log_d.delete();
    ci_req("setc75", 4'd2, 32'h000A_004B, w, r);
    rd("c75_cursor", 4'd8, 32'h000A_004B);
    put(8'h09);
    wait_idle("tab");
    rd("tab_cursor", 4'd8, 32'h000B_0000);
    put(8'h08);
    wait_idle("bs0");
    rd("bs0_cursor", 4'd8, 32'h000B_0000);
    chk("bs0_nowrite", log_a.size(), 32'd0);
    put(8'h51); put(8'h08); put(8'h01); put(8'h0A); put(8'h09);
    wait_idle("ctl");
    rd("ctl_cursor", 4'd8, 32'h000C_0008);
    chk("ctl_count", log_a.size(), 32'd2);
    if (log_a.size() == 2) begin
      chk("ctl_q", {11'd0, log_a[0], log_d[0]}, {11'd0, 13'd960, 8'h51});
      chk("ctl_bs", {11'd0, log_a[1], log_d[1]}, {11'd0, 13'd960, 8'h20});
    end

    // Clear, then overfill the FIFO while the screen is being cleared.
    log_a.delete(); log_d.delete();
    ci_req("clr1", 4'd1, 32'd0, w, r);
    chk("clr1_wait", w, 32'd0);
    for (int i = 0; i < 8; i++) begin
      ci_req("fill", 4'd0, 32'h61 + i, w, r);
      chk("fill_wait", w, 32'd0);
    end
    rd("fill_status", 4'd9, 32'h8000_0008);
    ci_req("push9", 4'd0, 32'h69, w, r);
    chk("push9_delayed", {31'd0, w > 4000}, 32'd1);
    wait_idle("fill");
    chk("fill_count", log_a.size(), 32'd4809);
    if (log_a.size() == 4809) begin
      chk("fill_clr_bad", clear_bad(0), 32'd0);
      bad = 0;
      for (int i = 0; i < 9; i++)
        if (log_a[4800+i] !== 13'(i) || log_d[4800+i] !== 8'(8'h61 + i)) bad++;
      chk("fill_chars_bad", bad, 32'd0);
    end
    chk("fill_scroll", {19'd0, scrollOffset}, 32'd0);

    // Clear arriving during CLEAR_LINE aborts it and flushes the FIFO.
    ci_req("setc_br", 4'd2, 32'h003B_004F, w, r);
    log_a.delete(); log_d.delete();
    put(8'h5A);
    repeat (4) @(negedge clock);
    put(8'h78); put(8'h79);
    rd("cl_status", 4'd9, 32'h8000_0002);
    ci_req("cl_clear", 4'd1, 32'd0, w, r);
    rd("cl_flushed", 4'd9, 32'h8000_0000);
    rd("cl_cursor", 4'd8, 32'h0000_0000);
    chk("cl_scroll", {19'd0, scrollOffset}, 32'd0);
    wait_idle("cl");
    sz = log_a.size();
    chk("cl_aborted", {31'd0, (sz > 4801) && (sz < 4881)}, 32'd1);
    if (sz >= 4800) chk("cl_restart_bad", clear_bad(sz - 4800), 32'd0);

    // Reset mid-operation discards queued characters.
    ci_req("rst_clr", 4'd1, 32'd0, w, r);
    put(8'h41); put(8'h42); put(8'h43);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_we", {31'd0, ramWe}, 32'd0);
    repeat (2) @(negedge clock);
    log_a.delete(); log_d.delete();
    reset = 1'b1;
    wait_idle("midrst");
    chk("midrst_count", log_a.size(), 32'd4800);
    rd("midrst_status", 4'd9, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
